// File: rtl/quad_step_gen.sv
// quad_step_gen: quadrature phase generator that walks a paddle decoder one
// count at a time toward a requested target position. Each count is a full
// four-phase cycle ending at 00; only the first edge of the cycle is counted
// by the decoder.
module quad_step_gen #(
  parameter int          STEP_DIV = 4,
  parameter logic [5:0]  INIT_POS = 6'd28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_game,
  input  logic       cmd_valid,
  input  logic [5:0] cmd_target,
  output logic       cmd_ready,
  output logic       enc_a,
  output logic       enc_b,
  output logic [5:0] cur_y,
  output logic       busy,
  output logic       done
);

  localparam int             HW        = $clog2(STEP_DIV) + 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(STEP_DIV - 1);

  // Phase levels as {a, b}
  localparam logic [1:0] ENC_IDLE = 2'b00;
  localparam logic [1:0] ENC_UP1  = 2'b10;
  localparam logic [1:0] ENC_DN1  = 2'b01;
  localparam logic [1:0] ENC_MID  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    P1,
    P2,
    P3,
    P4
  } state_t;

  state_t          state_reg;
  logic [HW-1:0]   hold_reg;
  logic            dir_up_reg;
  logic [5:0]      target_reg;
  logic [5:0]      cur_y_reg;
  logic [1:0]      enc_reg;
  logic            done_reg;
  logic            hold_end;

  assign hold_end = (hold_reg == HOLD_LAST);

  // Phase sequencer: latches targets, steps through P1..P4 with a hold
  // counter, and updates the mirrored position on every entry into P1.
  always_ff @(posedge clk) begin
    if (reset || reset_game) begin
      state_reg  <= IDLE;
      hold_reg   <= '0;
      dir_up_reg <= 1'b0;
      target_reg <= INIT_POS;
      cur_y_reg  <= INIT_POS;
      enc_reg    <= ENC_IDLE;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          hold_reg <= '0;
          enc_reg  <= ENC_IDLE;
          if (cmd_valid) begin
            target_reg <= cmd_target;
            if (cmd_target > cur_y_reg) begin
              dir_up_reg <= 1'b1;
              cur_y_reg  <= cur_y_reg + 6'd1;
              enc_reg    <= ENC_UP1;
              state_reg  <= P1;
            end else if (cmd_target < cur_y_reg) begin
              dir_up_reg <= 1'b0;
              cur_y_reg  <= cur_y_reg - 6'd1;
              enc_reg    <= ENC_DN1;
              state_reg  <= P1;
            end else begin
              // Already there: acknowledge without emitting any edge
              done_reg <= 1'b1;
            end
          end
        end
        P1: begin
          if (hold_end) begin
            hold_reg  <= '0;
            enc_reg   <= ENC_MID;
            state_reg <= P2;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        P2: begin
          if (hold_end) begin
            hold_reg  <= '0;
            enc_reg   <= dir_up_reg ? ENC_DN1 : ENC_UP1;
            state_reg <= P3;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        P3: begin
          if (hold_end) begin
            hold_reg  <= '0;
            enc_reg   <= ENC_IDLE;
            state_reg <= P4;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        P4: begin
          if (hold_end) begin
            hold_reg <= '0;
            if (cur_y_reg == target_reg) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else begin
              // Next count: the counted edge and the position update coincide
              state_reg <= P1;
              if (dir_up_reg) begin
                cur_y_reg <= cur_y_reg + 6'd1;
                enc_reg   <= ENC_UP1;
              end else begin
                cur_y_reg <= cur_y_reg - 6'd1;
                enc_reg   <= ENC_DN1;
              end
            end
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          hold_reg  <= '0;
          enc_reg   <= ENC_IDLE;
        end
      endcase
    end
  end

  assign enc_a     = enc_reg[1];
  assign enc_b     = enc_reg[0];
  assign cur_y     = cur_y_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != IDLE);
  assign cmd_ready = (state_reg == IDLE);

endmodule

// File: doc/quad_step_gen.md
# quad_step_gen

Quadrature transmitter for the paddle-movement decoder. It accepts a target paddle position, compares it with its mirror of the paddle position, and emits enc_a/enc_b phase sequences. Each full sequence moves the decoder's paddle by exactly one count toward the target. The block drives the computer-controlled paddle and serves as bench stimulus for the decoder. It sits between the AI/test controller and one encoder input pair of paddle_movement.

## Interface
- STEP_DIV, 4: clock cycles each phase state is held; must be ≥1; hold counter width is clog2(STEP_DIV)+1.
- INIT_POS, 28: position loaded on reset and reset_game; matches the decoder's reset value.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock; the polarity and synchronicity are fixed.
- reset_game  in  1  synchronous game restart, sampled on clk; same effect as reset on this block.
- cmd_valid  in  1  target request.
- cmd_target  in  6  requested paddle top position.
- cmd_ready  out  1  high only in IDLE.
- enc_a  out  1  quadrature phase A, registered.
- enc_b  out  1  quadrature phase B, registered.
- cur_y  out  6  position the decoder holds after the edges emitted so far.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when cur_y reaches the accepted target.

## Operation
- Decoder rules this block must satisfy:
  - A rising edge of enc_a while enc_b=0 increments the decoder by 1.
  - A rising edge of enc_b while enc_a=0 decrements it by 1.
  - All other edges are ignored.
- Up-step phase sequence (a,b): 00→10→11→01→00. Only the first edge counts.
- Down-step phase sequence (a,b): 00→01→11→10→00. Only the first edge counts.
- The idle level is always 00.
- States:
  - IDLE: outputs 00.
  - P1: 10 for up, 01 for down.
  - P2: 11.
  - P3: 01 for up, 10 for down.
  - P4: 00.
- Accept:
  - A command is accepted on cycle k when cmd_valid and cmd_ready are both high.
  - Target and direction are latched: up if cmd_target>cur_y, down if cmd_target<cur_y.
  - No wrap-around traversal; the block never crosses 63↔0.
  - If cmd_target==cur_y: stay in IDLE, pulse done at k+1, emit no edges.
- Transitions:
  - IDLE→P1 on accept.
  - Each of P1, P2, P3 and P4 lasts STEP_DIV cycles, then advances to the next state.
  - At the end of P4: if cur_y==target, go to IDLE and pulse done; otherwise go to P1 for the next step.
- cur_y changes by ±1 in the same cycle enc_a/enc_b enter P1. Arithmetic is 6-bit.
- cmd_valid while busy is ignored; it is not queued.
- reset or reset_game in any state, on the next edge:
  - State returns to IDLE and outputs go to 00.
  - cur_y=INIT_POS, hold counter cleared, done=0.
  - Dropping to 00 from any phase produces only falling edges, so no spurious count.
- Output values during reset: enc_a=0, enc_b=0, cur_y=INIT_POS, busy=0, done=0, cmd_ready=1.

## Timing
- Accept at edge k: enc outputs show P1 levels and cur_y is updated from cycle k+1.
- A step of 1 count takes 4·STEP_DIV cycles. N counts take N·4·STEP_DIV cycles.
- After the last P4 completes, done=1 and busy=0 for exactly one cycle; cmd_ready=1 in that same cycle.
- A new command can be accepted on the done cycle, so the next P1 starts one cycle later.
- The minimum spacing between counted edges is 4·STEP_DIV cycles. The decoder sees each edge with enc levels stable for STEP_DIV cycles on each side.
- Simultaneous reset_game and cmd_valid: reset wins and the command is dropped.

## Test plan
- Reset then idle:
  - Assert reset 1 cycle.
  - Required: cur_y=28, enc=00, cmd_ready=1, no edges for 100 cycles.
- Move up, STEP_DIV=4, target 30 from 28:
  - Required: enc sequence 10,11,01,00 each held 4 cycles, twice.
  - cur_y reads 29 at cycle k+1 and 30 at k+17.
  - done pulses at k+33.
  - A paired paddle_movement reads p1y=30.
- Move down, target 26 from 28:
  - Required: sequence 01,11,10,00 twice; decoder reads 26; done after 32 cycles.
- Target 28 from 28:
  - Required: done at k+1, enc stays 00.
- Command while busy:
  - Issue target 35 during a move to 30.
  - Required: ignored; motion ends at 30.
- reset_game mid-P2 of an up step from 28:
  - Required: enc→00 next cycle, cur_y=28, busy=0, decoder value equals cur_y after its own reset_game.
